riscv_jtag_tap: RTL and testbench
=================================

Name: riscv_jtag_tap

Overview:
IEEE 1149.1 TAP controller that fronts the RISC-V DTM on the JTAG pins. It runs the 16-state TAP FSM and owns the instruction register, the IDCODE register and the BYPASS register. It decodes the DTMCS and DMI instructions into select strobes and multiplexes TDO from the internal registers and from the serial outputs of the DTM's DTMCS and DMI shift registers. The DTM instantiates this block and consumes its shift/capture/update/pause strobes.

Parameters:
IR_WIDTH, 5, instruction register width.
IDCODE_VALUE, 32'h0000_0001, value captured into the IDCODE DR; bit 0 must be 1.
IDCODE_INSTR, 5'h01, opcode selecting IDCODE.
DTMCS_INSTR, 5'h10, opcode selecting DTMCS.
DMI_INSTR, 5'h11, opcode selecting DMI.
BYPASS_INSTR, 5'h1F, opcode selecting BYPASS; every undefined opcode also selects BYPASS.

Ports:
tck_i  in  1  JTAG clock.
trst_i  in  1  reset, asynchronous, active-high.
tms_i  in  1  test mode select, sampled on tck rising edge.
tdi_i  in  1  serial data in.
tdo_o  out  1  serial data out, changes on tck falling edge.
tdo_oe_o  out  1  TDO output enable, high only in Shift-IR/Shift-DR (registered on falling edge).
tdi_o  out  1  tdi_i forwarded to the DTM shift registers.
test_logic_reset_o  out  1  FSM in Test-Logic-Reset.
run_test_idle_o  out  1  FSM in Run-Test/Idle.
capture_dr_o  out  1  FSM in Capture-DR.
shift_dr_o  out  1  FSM in Shift-DR.
pause_dr_o  out  1  FSM in Pause-DR.
update_dr_o  out  1  FSM in Update-DR.
dtmcs_select_o  out  1  IR == DTMCS_INSTR.
dmi_select_o  out  1  IR == DMI_INSTR.
dtmcs_tdo_i  in  1  LSB of the DTM's DTMCS shift register.
dmi_tdo_i  in  1  LSB of the DTM's DMI shift register.

Behaviour:
- FSM: standard 16 states (TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, and the IR mirrors). Transitions follow 1149.1 on tck rising edge, keyed on tms_i.
- Any state followed by 5 consecutive rising edges with TMS=1 reaches TLR.
- trst_i asynchronously forces the following: state=TLR, IR=IDCODE_INSTR, ir_shift=0, bypass=0, idcode_shift=IDCODE_VALUE, tdo_o=0, tdo_oe_o=0.
- Entering TLR through TMS has the same effect on IR: it loads IDCODE_INSTR on the falling edge while in TLR.
- State-strobe outputs are combinational decodes of the registered state. They are all 0 during reset, except test_logic_reset_o=1.
- IR shift register, on rising edge:
  - CAP_IR: loads {0..,2'b01}.
  - SH_IR: shifts right, tdi_i into the MSB.
- IR, on falling edge: latches ir_shift in UPD_IR.
- Select outputs decode from IR only, so they are stable from UPD_IR through the next UPD_IR.
- IDCODE DR, on rising edge: CAP_DR with IDCODE selected loads IDCODE_VALUE; SH_DR shifts right with tdi_i in.
- BYPASS DR, on rising edge: CAP_DR loads 0; SH_DR loads tdi_i. This gives 1-cycle delay.
- DTMCS/DMI DRs are external to this block. The DTM shifts them on the rising edge while shift_dr_o and the matching select are high.
- TDO mux, registered on falling edge:
  - SH_IR: ir_shift[0].
  - SH_DR: per select, idcode_shift[0], dtmcs_tdo_i, dmi_tdo_i, or bypass.
  - Otherwise: hold the value and drop tdo_oe_o.
- TDO latency: the first bit appears on the falling edge after entering the shift state, i.e. it reflects the captured LSB.
- PA_DR/PA_IR: no shifting; register contents hold.
- trst_i mid-shift: the scan is aborted, nothing is updated, and the selects return to IDCODE (dtmcs_select_o=dmi_select_o=0).

Decomposition:
- riscv_dm_pkg: tap_state_t enum (4-bit), JTAG_IR_WIDTH, IDCODE/DTMCS/DMI/BYPASS opcode constants, default IDCODE value.
- Sub-module riscv_jtag_tap_fsm: the 16-state FSM with state-decode outputs, which the bench can exercise standalone.
- IR, DRs and TDO mux live in riscv_jtag_tap.

Test Plan:
- trst_i pulse, then TLR->RTI->SEL_DR->CAP_DR, then 32 SH_DR cycles -> tdo_o serially returns 32'h0000_0001, LSB first; tdo_oe_o=1 only during shift.
- From SH_DR, hold TMS=1 for 5 cycles -> test_logic_reset_o=1, IR reads back IDCODE_INSTR.
- IR scan shifting in 5'h11 -> tdo_o emits 1,0,0,0,0 (capture pattern); after UPD_IR, dmi_select_o=1 and dtmcs_select_o=0; DR scan with dmi_tdo_i driven -> tdo_o mirrors dmi_tdo_i delayed half a cycle.
- IR=5'h1F, and separately IR=5'h05 -> 8-bit DR scan of 8'hA5 returns 0 followed by 8'hA5 delayed by one bit.
- IR=5'h10, enter PA_DR for 4 cycles then resume shifting -> pause_dr_o=1 in pause, no bits lost; dtmcs_select_o stays 1 throughout.
- Assert trst_i asynchronously mid-SH_IR while loading 5'h11 -> immediate TLR, IR=IDCODE, dmi_select_o=0, tdo_oe_o=0.

Source files
------------

// File: rtl/riscv_dm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_dm_pkg : JTAG TAP state type, opcodes and next-state helper for the DTM
// Rev 1.0
// ---------------------------------------------------------------------------
package riscv_dm_pkg;

  localparam int unsigned JTAG_IR_WIDTH = 5;

  localparam logic [JTAG_IR_WIDTH-1:0] IDCODE_OPCODE = 5'h01;
  localparam logic [JTAG_IR_WIDTH-1:0] DTMCS_OPCODE  = 5'h10;
  localparam logic [JTAG_IR_WIDTH-1:0] DMI_OPCODE    = 5'h11;
  localparam logic [JTAG_IR_WIDTH-1:0] BYPASS_OPCODE = 5'h1F;

  localparam logic [31:0] DEFAULT_IDCODE = 32'h0000_0001;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  n = tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  n = tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
      default:    n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_jtag_tap_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_jtag_tap_fsm : 16-state IEEE 1149.1 TAP controller with state decodes
// Rev 1.0
// ---------------------------------------------------------------------------
module riscv_jtag_tap_fsm
  import riscv_dm_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output tap_state_t state_o,
  output logic       test_logic_reset_o,
  output logic       run_test_idle_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       pause_dr_o,
  output logic       update_dr_o
);

  tap_state_t state_q;

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q <= TAP_TLR;
    end else begin
      state_q <= tap_next(state_q, tms_i);
    end
  end

  assign state_o            = state_q;
  assign test_logic_reset_o = (state_q == TAP_TLR);
  assign run_test_idle_o    = (state_q == TAP_RTI);
  assign capture_dr_o       = (state_q == TAP_CAP_DR);
  assign shift_dr_o         = (state_q == TAP_SH_DR);
  assign pause_dr_o         = (state_q == TAP_PA_DR);
  assign update_dr_o        = (state_q == TAP_UPD_DR);

endmodule
`default_nettype wire

// File: rtl/riscv_jtag_tap.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_jtag_tap : JTAG TAP fronting the RISC-V DTM (IR, IDCODE, BYPASS, TDO mux)
// Rev 1.0
// ---------------------------------------------------------------------------
module riscv_jtag_tap
  import riscv_dm_pkg::*;
#(
  parameter int unsigned          IR_WIDTH     = JTAG_IR_WIDTH,
  parameter logic [31:0]          IDCODE_VALUE = DEFAULT_IDCODE,
  parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR = IR_WIDTH'(IDCODE_OPCODE),
  parameter logic [IR_WIDTH-1:0]  DTMCS_INSTR  = IR_WIDTH'(DTMCS_OPCODE),
  parameter logic [IR_WIDTH-1:0]  DMI_INSTR    = IR_WIDTH'(DMI_OPCODE),
  parameter logic [IR_WIDTH-1:0]  BYPASS_INSTR = IR_WIDTH'(BYPASS_OPCODE)
) (
  input  logic tck_i,
  input  logic trst_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  output logic tdi_o,
  output logic test_logic_reset_o,
  output logic run_test_idle_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic dtmcs_select_o,
  output logic dmi_select_o,
  input  logic dtmcs_tdo_i,
  input  logic dmi_tdo_i
);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_shift_q;
  logic [31:0]         idcode_shift_q;
  logic                bypass_q;
  logic                tdo_q;
  logic                tdo_d;
  logic                tdo_oe_q;
  logic                idcode_sel;

  riscv_jtag_tap_fsm u_fsm (
    .tck_i              (tck_i),
    .trst_i             (trst_i),
    .tms_i              (tms_i),
    .state_o            (state),
    .test_logic_reset_o (test_logic_reset_o),
    .run_test_idle_o    (run_test_idle_o),
    .capture_dr_o       (capture_dr_o),
    .shift_dr_o         (shift_dr_o),
    .pause_dr_o         (pause_dr_o),
    .update_dr_o        (update_dr_o)
  );

  // BYPASS_INSTR and every unlisted opcode fall through to the bypass path
  assign idcode_sel     = (ir_q == IDCODE_INSTR);
  assign dtmcs_select_o = (ir_q == DTMCS_INSTR);
  assign dmi_select_o   = (ir_q == DMI_INSTR);
  assign tdi_o          = tdi_i;

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      ir_shift_q     <= '0;
      idcode_shift_q <= IDCODE_VALUE;
      bypass_q       <= 1'b0;
    end else begin
      case (state)
        TAP_CAP_IR: ir_shift_q <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
        TAP_SH_IR:  ir_shift_q <= {tdi_i, ir_shift_q[IR_WIDTH-1:1]};
        TAP_CAP_DR: begin
          bypass_q <= 1'b0;
          if (idcode_sel) idcode_shift_q <= IDCODE_VALUE;
        end
        TAP_SH_DR: begin
          bypass_q <= tdi_i;
          if (idcode_sel) idcode_shift_q <= {tdi_i, idcode_shift_q[31:1]};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo_d = tdo_q;
    if (state == TAP_SH_IR) begin
      tdo_d = ir_shift_q[0];
    end else if (state == TAP_SH_DR) begin
      if (idcode_sel)          tdo_d = idcode_shift_q[0];
      else if (dtmcs_select_o) tdo_d = dtmcs_tdo_i;
      else if (dmi_select_o)   tdo_d = dmi_tdo_i;
      else                     tdo_d = bypass_q;
    end
  end

  // Falling-edge half: IR update and TDO launch, so TDO is stable at the next rising edge
  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      ir_q     <= IDCODE_INSTR;
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= (state == TAP_SH_IR) || (state == TAP_SH_DR);
      if (state == TAP_TLR)         ir_q <= IDCODE_INSTR;
      else if (state == TAP_UPD_IR) ir_q <= ir_shift_q;
    end
  end

  assign tdo_o    = tdo_q;
  assign tdo_oe_o = tdo_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_jtag_tap.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_riscv_jtag_tap : directed scans against a table-driven TAP reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_riscv_jtag_tap;

  logic tck = 1'b0;
  logic trst_i = 1'b0, tms_i = 1'b0, tdi_i = 1'b0;
  logic dtmcs_tdo_i = 1'b0, dmi_tdo_i = 1'b0;
  logic tdo_o, tdo_oe_o, tdi_o;
  logic test_logic_reset_o, run_test_idle_o, capture_dr_o, shift_dr_o;
  logic pause_dr_o, update_dr_o, dtmcs_select_o, dmi_select_o;

  riscv_jtag_tap dut (
    .tck_i              (tck),
    .trst_i             (trst_i),
    .tms_i              (tms_i),
    .tdi_i              (tdi_i),
    .tdo_o              (tdo_o),
    .tdo_oe_o           (tdo_oe_o),
    .tdi_o              (tdi_o),
    .test_logic_reset_o (test_logic_reset_o),
    .run_test_idle_o    (run_test_idle_o),
    .capture_dr_o       (capture_dr_o),
    .shift_dr_o         (shift_dr_o),
    .pause_dr_o         (pause_dr_o),
    .update_dr_o        (update_dr_o),
    .dtmcs_select_o     (dtmcs_select_o),
    .dmi_select_o       (dmi_select_o),
    .dtmcs_tdo_i        (dtmcs_tdo_i),
    .dmi_tdo_i          (dmi_tdo_i)
  );

  always #10 tck = ~tck;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. State codes: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,6 PaDR,
  // 7 Ex2DR,8 UpdDR,9 SelIR,10 CapIR,11 ShIR,12 Ex1IR,13 PaIR,14 Ex2IR,15 UpdIR
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int          m_st, m_irsh, m_ir;
  logic [31:0] m_idc;
  bit          m_byp, m_tdo, m_oe;

  always @(posedge tck or posedge trst_i) begin
    if (trst_i) begin
      m_st = 0; m_irsh = 0; m_idc = 32'h1; m_byp = 1'b0;
    end else begin
      case (m_st)
        10: m_irsh = 1;
        11: m_irsh = (m_irsh >> 1) | (int'(tdi_i) << 4);
        3:  begin m_byp = 1'b0; if (m_ir == 1) m_idc = 32'h1; end
        4:  begin m_byp = tdi_i; m_idc = (m_idc >> 1) | (32'(tdi_i) << 31); end
        default: ;
      endcase
      m_st = tms_i ? nxt1[m_st] : nxt0[m_st];
    end
  end

  always @(negedge tck or posedge trst_i) begin
    if (trst_i) begin
      m_ir = 1; m_tdo = 1'b0; m_oe = 1'b0;
    end else begin
      if (m_st == 11) begin
        m_tdo = ((m_irsh & 1) != 0); m_oe = 1'b1;
      end else if (m_st == 4) begin
        m_oe = 1'b1;
        case (m_ir)
          1:       m_tdo = m_idc[0];
          16:      m_tdo = dtmcs_tdo_i;
          17:      m_tdo = dmi_tdo_i;
          default: m_tdo = m_byp;
        endcase
      end else begin
        m_oe = 1'b0;
      end
      if (m_st == 0)       m_ir = 1;
      else if (m_st == 15) m_ir = m_irsh;
    end
  end

  always @(negedge tck) begin
    if (chk_en) begin
      #1;
      check("cycle_outputs",
            {21'd0, test_logic_reset_o, run_test_idle_o, capture_dr_o, shift_dr_o, pause_dr_o,
             update_dr_o, dtmcs_select_o, dmi_select_o, tdo_o, tdo_oe_o, tdi_o},
            {21'd0, m_st == 0, m_st == 1, m_st == 3, m_st == 4, m_st == 6, m_st == 8,
             m_ir == 16, m_ir == 17, m_tdo, m_oe, tdi_i});
    end
  end

  // One TCK cycle: sample TDO launched at this falling edge, then drive the next inputs
  task automatic step(input bit tms, input bit tdi, input bit ext, output bit seen);
    @(negedge tck);
    #2;
    seen        = tdo_o;
    tms_i       = tms;
    tdi_i       = tdi;
    dtmcs_tdo_i = ext;
    dmi_tdo_i   = ext;
  endtask

  task automatic mv(input bit tms);
    bit d;
    step(tms, 1'b0, 1'b0, d);
  endtask

  task automatic scan(input int n, input logic [31:0] data, input logic [31:0] ext,
                      output logic [31:0] out);
    bit b;
    out = '0;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, data[i], ext[i], b);
      out[i] = b;
    end
  endtask

  task automatic dr_scan(input int n, input logic [31:0] data, input logic [31:0] ext,
                         output logic [31:0] out);
    mv(1); mv(0); mv(0);
    scan(n, data, ext, out);
    mv(1); mv(0);
  endtask

  task automatic ir_scan(input logic [31:0] val, output logic [31:0] out);
    mv(1); mv(1); mv(0); mv(0);
    scan(5, val, 32'd0, out);
    mv(1); mv(0);
  endtask

  initial begin
    logic [31:0] o;
    bit          b;

    #5 trst_i = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_tlr",  test_logic_reset_o, 1);
    check("rst_oe",   tdo_oe_o, 0);
    check("rst_sel",  {dtmcs_select_o, dmi_select_o}, 0);
    @(negedge tck); #2 trst_i = 1'b0;

    mv(0);
    dr_scan(32, 32'd0, 32'd0, o);
    check("idcode_scan", o, 32'h0000_0001);

    ir_scan(32'h11, o);
    check("ir_capture", o & 32'h1F, 32'h01);
    check("dmi_sel",    {dtmcs_select_o, dmi_select_o}, 2'b01);
    dr_scan(9, 32'd0, 32'h3C, o);
    check("dmi_mirror", o & 32'h1FF, 32'h078);

    ir_scan(32'h1F, o);
    dr_scan(9, 32'hA5, 32'd0, o);
    check("bypass_1f", o & 32'h1FF, 32'h14A);

    ir_scan(32'h05, o);
    check("undef_sel", {dtmcs_select_o, dmi_select_o}, 2'b00);
    dr_scan(9, 32'hA5, 32'd0, o);
    check("bypass_05", o & 32'h1FF, 32'h14A);

    ir_scan(32'h10, o);
    check("dtmcs_sel", {dtmcs_select_o, dmi_select_o}, 2'b10);
    mv(1); mv(0); mv(0);
    step(1'b0, 1'b1, 1'b1, b);
    step(1'b0, 1'b0, 1'b0, b);
    step(1'b1, 1'b1, 1'b1, b);
    mv(0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) mv(0);
      @(negedge tck); #1;
      check("pause_dr", {pause_dr_o, dtmcs_select_o}, 2'b11);
    end
    mv(1); mv(0);
    for (int i = 0; i < 4; i++) step(1'b0, i[0], ~i[0], b);
    step(1'b1, 1'b1, 1'b0, b);
    mv(1); mv(0);
    check("dtmcs_hold", dtmcs_select_o, 1);

    mv(1); mv(0); mv(0);
    for (int i = 0; i < 5; i++) mv(1);
    @(negedge tck); #2;
    check("tms_tlr", {test_logic_reset_o, dtmcs_select_o}, 2'b10);
    mv(0);
    dr_scan(4, 32'd0, 32'd0, o);
    check("tlr_idcode", o & 32'hF, 32'h1);

    ir_scan(32'h10, o);
    mv(1); mv(1); mv(0); mv(0);
    step(1'b0, 1'b1, 1'b0, b);
    step(1'b0, 1'b0, 1'b0, b);
    @(negedge tck); #5 trst_i = 1'b1;
    #1;
    check("trst_mid_tlr", {test_logic_reset_o, shift_dr_o}, 2'b10);
    check("trst_mid_sel", {dtmcs_select_o, dmi_select_o}, 2'b00);
    check("trst_mid_tdo", {tdo_o, tdo_oe_o}, 2'b00);
    @(negedge tck); #2 trst_i = 1'b0;
    mv(0);
    dr_scan(4, 32'd0, 32'd0, o);
    check("post_trst_idcode", o & 32'hF, 32'h1);

    repeat (2) @(negedge tck);
    chk_en = 1'b0;
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
